// File: rtl/hack_pkg.sv
// Shared definitions for the Hack arithmetic blocks: sequencer state encoding.
package hack_pkg;
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/serial_add_seq_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial adder.
interface serial_add_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/FullAdder.sv
// 1-bit full-adder cell, the only arithmetic in the serial datapath.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract: one FullAdder reused LSB-first over WIDTH cycles,
// with a start/busy/done handshake and registered sum, carry-out and overflow.
module serial_add_seq
    import hack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_add_seq_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_cmsb;

    logic             w_s;
    logic             w_c;

    FullAdder u_fa (
        .a     (r_a[0]),
        .b     (r_b[0]),
        .c     (r_carry),
        .sum   (w_s),
        .carry (w_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cmsb  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_acc   <= {w_s, r_acc[WIDTH-1:1]};
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    // Last bit: the carry entering this cell is the carry into the MSB.
                    if (r_cnt == LAST_BIT) begin
                        r_state <= ST_DONE;
                        r_sum   <= {w_s, r_acc[WIDTH-1:1]};
                        r_cout  <= w_c;
                        r_cmsb  <= r_carry;
                    end
                end
                default: begin
                    if (bus.start) begin
                        r_state <= ST_RUN;
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub | bus.cin;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = (r_state == ST_RUN);
    assign bus.done = (r_state == ST_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_cmsb ^ r_cout;
endmodule
